// File: rtl/test_status_monitor.sv
// Consumes ALU pass/fail/done reports: counts events, keeps the first failure, logs every
// event in a show-ahead FIFO drained over valid/ready, and halts once DONE is seen and the log is empty.
module test_status_monitor #(
  parameter int LOG_DEPTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Valid,
  input  logic [1:0]                     i_Pass_Done_Change,
  input  logic [15:0]                    i_Pass_Done_Value,
  input  logic                           i_Log_Ready,
  output logic                           o_Log_Valid,
  output logic [17:0]                    o_Log_Entry,
  output logic [$clog2(LOG_DEPTH):0]     o_Log_Level,
  output logic                           o_Log_Overflow,
  output logic [COUNT_WIDTH-1:0]         o_Pass_Count,
  output logic [COUNT_WIDTH-1:0]         o_Fail_Count,
  output logic                           o_First_Fail_Valid,
  output logic [15:0]                    o_First_Fail_Value,
  output logic                           o_Done,
  output logic [15:0]                    o_Done_Value,
  output logic                           o_Halt
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(LOG_DEPTH);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] CHG_PASS = 2'd1;
  localparam logic [1:0] CHG_FAIL = 2'd2;
  localparam logic [1:0] CHG_DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [17:0]            mem_q [LOG_DEPTH];
  logic [17:0]            mem_d [LOG_DEPTH];
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [COUNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic                   ff_vld_q, ff_vld_d;
  logic [15:0]            ff_val_q, ff_val_d;
  logic                   done_q, done_d;
  logic [15:0]            done_val_q, done_val_d;

  logic evt, pop, full, push;

  // Events only count while running; a pop frees a slot for a same-cycle push when full.
  assign evt  = i_Valid && (i_Pass_Done_Change != 2'd0) && (state_q == ST_RUN);
  assign pop  = (level_q != '0) && i_Log_Ready;
  assign full = (level_q == FULL_LVL);
  assign push = evt && (!full || pop);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    mem_d      = mem_q;
    ovf_d      = ovf_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ff_vld_d   = ff_vld_q;
    ff_val_d   = ff_val_q;
    done_d     = done_q;
    done_val_d = done_val_q;

    if (push) begin
      mem_d[wr_ptr_q] = {i_Pass_Done_Change, i_Pass_Done_Value};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (evt && full && !pop) begin
      ovf_d = 1'b1;
    end

    if (evt) begin
      case (i_Pass_Done_Change)
        CHG_PASS: begin
          if (pass_cnt_q != {COUNT_WIDTH{1'b1}}) pass_cnt_d = pass_cnt_q + COUNT_WIDTH'(1);
        end
        CHG_FAIL: begin
          if (fail_cnt_q != {COUNT_WIDTH{1'b1}}) fail_cnt_d = fail_cnt_q + COUNT_WIDTH'(1);
          if (!ff_vld_q) begin
            ff_vld_d = 1'b1;
            ff_val_d = i_Pass_Done_Value;
          end
        end
        CHG_DONE: begin
          done_d     = 1'b1;
          done_val_d = i_Pass_Done_Value;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_RUN:    if (evt && (i_Pass_Done_Change == CHG_DONE)) state_d = ST_DRAIN;
      ST_DRAIN:  if (level_q == '0) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) mem_q[i] <= '0;
      ovf_q      <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_vld_q   <= 1'b0;
      ff_val_q   <= '0;
      done_q     <= 1'b0;
      done_val_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_q      <= mem_d;
      ovf_q      <= ovf_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vld_q   <= ff_vld_d;
      ff_val_q   <= ff_val_d;
      done_q     <= done_d;
      done_val_q <= done_val_d;
    end
  end

  assign o_Log_Valid        = (level_q != '0);
  assign o_Log_Entry        = mem_q[rd_ptr_q];
  assign o_Log_Level        = level_q;
  assign o_Log_Overflow     = ovf_q;
  assign o_Pass_Count       = pass_cnt_q;
  assign o_Fail_Count       = fail_cnt_q;
  assign o_First_Fail_Valid = ff_vld_q;
  assign o_First_Fail_Value = ff_val_q;
  assign o_Done             = done_q;
  assign o_Done_Value       = done_val_q;
  assign o_Halt             = (state_q == ST_HALTED);

endmodule

// File: tb/tb_test_status_monitor.sv
// Randomized and directed bench for test_status_monitor against a queue-based reference model.
module tb_test_status_monitor;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int MAXC  = 65535;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Valid = 1'b0;
  logic [1:0]  i_Pass_Done_Change = 2'd0;
  logic [15:0] i_Pass_Done_Value = 16'd0;
  logic        i_Log_Ready = 1'b0;
  logic        o_Log_Valid;
  logic [17:0] o_Log_Entry;
  logic [LW-1:0] o_Log_Level;
  logic        o_Log_Overflow;
  logic [15:0] o_Pass_Count, o_Fail_Count;
  logic        o_First_Fail_Valid;
  logic [15:0] o_First_Fail_Value;
  logic        o_Done;
  logic [15:0] o_Done_Value;
  logic        o_Halt;

  test_status_monitor #(.LOG_DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Valid(i_Valid),
    .i_Pass_Done_Change(i_Pass_Done_Change), .i_Pass_Done_Value(i_Pass_Done_Value),
    .i_Log_Ready(i_Log_Ready), .o_Log_Valid(o_Log_Valid), .o_Log_Entry(o_Log_Entry),
    .o_Log_Level(o_Log_Level), .o_Log_Overflow(o_Log_Overflow),
    .o_Pass_Count(o_Pass_Count), .o_Fail_Count(o_Fail_Count),
    .o_First_Fail_Valid(o_First_Fail_Valid), .o_First_Fail_Value(o_First_Fail_Value),
    .o_Done(o_Done), .o_Done_Value(o_Done_Value), .o_Halt(o_Halt)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the log is a plain queue, "running" simply means DONE not yet seen.
  logic [17:0] q[$];
  int          m_pass, m_fail;
  bit          m_ff_vld, m_done, m_ovf, m_halt;
  logic [15:0] m_ff_val, m_done_val;

  task automatic model_clear();
    q.delete();
    m_pass = 0; m_fail = 0; m_ff_vld = 0; m_ff_val = '0;
    m_done = 0; m_done_val = '0; m_ovf = 0; m_halt = 0;
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic [15:0] val,
                      input logic rdy, input logic rst = 1'b0);
    int pre;
    bit pop, ev;
    i_Reset = rst; i_Valid = v; i_Pass_Done_Change = c;
    i_Pass_Done_Value = val; i_Log_Ready = rdy;
    @(posedge i_Clk);
    if (rst) begin
      model_clear();
    end else begin
      pre = q.size();
      pop = (pre > 0) && rdy;
      ev  = v && (c != 2'd0) && !m_done;
      if (m_done && !m_halt && pre == 0) m_halt = 1;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (pre < DEPTH || pop) q.push_back({c, val});
        else m_ovf = 1;
        if (c == 2'd1 && m_pass < MAXC) m_pass++;
        if (c == 2'd2) begin
          if (m_fail < MAXC) m_fail++;
          if (!m_ff_vld) begin m_ff_vld = 1; m_ff_val = val; end
        end
        if (c == 2'd3) begin m_done = 1; m_done_val = val; end
      end
    end
    @(negedge i_Clk);
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    n_checks++; if (o_Log_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_Log_Valid); else n_pass++;
    n_checks++; if (o_Log_Level !== '0) $display("FAIL reset_level got %0d want 0", o_Log_Level); else n_pass++;
    n_checks++; if (o_Pass_Count !== 16'd0 || o_Fail_Count !== 16'd0)
      $display("FAIL reset_counts got %h/%h want 0/0", o_Pass_Count, o_Fail_Count); else n_pass++;
    n_checks++; if ({o_Log_Overflow, o_First_Fail_Valid, o_Done, o_Halt} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {o_Log_Overflow, o_First_Fail_Valid, o_Done, o_Halt}); else n_pass++;
    n_checks++; if ({o_Log_Entry, o_First_Fail_Value, o_Done_Value} !== 50'd0)
      $display("FAIL reset_values got %h want 0", {o_Log_Entry, o_First_Fail_Value, o_Done_Value}); else n_pass++;
  endtask

  task automatic test_basic();
    logic [17:0] exp_e [3];
    exp_e[0] = 18'h10001; exp_e[1] = 18'h10002; exp_e[2] = 18'h20003;
    step(0, 0, 0, 0, 1);
    step(1, 1, 16'h0001, 0);
    step(1, 1, 16'h0002, 0);
    step(1, 2, 16'h0003, 0);
    n_checks++; if (o_Pass_Count !== 16'd2) $display("FAIL basic_pass got %0d want 2", o_Pass_Count); else n_pass++;
    n_checks++; if (o_Fail_Count !== 16'd1) $display("FAIL basic_fail got %0d want 1", o_Fail_Count); else n_pass++;
    n_checks++; if (o_First_Fail_Value !== 16'h0003 || o_First_Fail_Valid !== 1'b1)
      $display("FAIL basic_first_fail got %b/%h want 1/0003", o_First_Fail_Valid, o_First_Fail_Value); else n_pass++;
    n_checks++; if (o_Log_Level !== LW'(3)) $display("FAIL basic_level got %0d want 3", o_Log_Level); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (o_Log_Valid !== 1'b1 || o_Log_Entry !== exp_e[i])
        $display("FAIL basic_entry%0d got %b/%h want 1/%h", i, o_Log_Valid, o_Log_Entry, exp_e[i]); else n_pass++;
      step(0, 0, 0, 1);
    end
    n_checks++; if (o_Log_Valid !== 1'b0) $display("FAIL basic_empty got %b want 0", o_Log_Valid); else n_pass++;
  endtask

  task automatic test_first_fail();
    step(0, 0, 0, 0, 1);
    step(1, 2, 16'h0010, 1);
    step(1, 2, 16'h0020, 1);
    n_checks++; if (o_First_Fail_Value !== 16'h0010) $display("FAIL ffhold_value got %h want 0010", o_First_Fail_Value); else n_pass++;
    n_checks++; if (o_Fail_Count !== 16'd2) $display("FAIL ffhold_count got %0d want 2", o_Fail_Count); else n_pass++;
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) step(1, 1, 16'(i), 0);
    n_checks++; if (o_Log_Level !== LW'(8)) $display("FAIL ovf_level got %0d want 8", o_Log_Level); else n_pass++;
    n_checks++; if (o_Log_Overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", o_Log_Overflow); else n_pass++;
    n_checks++; if (o_Pass_Count !== 16'd10) $display("FAIL ovf_pass got %0d want 10", o_Pass_Count); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (o_Log_Entry !== {2'b01, 16'(i)}) $display("FAIL ovf_drain%0d got %h want %h", i, o_Log_Entry, {2'b01, 16'(i)}); else n_pass++;
      step(0, 0, 0, 1);
    end
    n_checks++; if (o_Log_Valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", o_Log_Valid); else n_pass++;

    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, 1, 16'(i), 0);
    step(1, 1, 16'd9, 1);
    n_checks++; if (o_Log_Overflow !== 1'b0 || o_Log_Level !== LW'(8))
      $display("FAIL ovf_pushpop got %b/%0d want 0/8", o_Log_Overflow, o_Log_Level); else n_pass++;
    for (int i = 2; i <= 9; i++) begin
      n_checks++; if (o_Log_Entry !== {2'b01, 16'(i)}) $display("FAIL ovf_pp_drain%0d got %h want %h", i, o_Log_Entry, {2'b01, 16'(i)}); else n_pass++;
      step(0, 0, 0, 1);
    end
  endtask

  task automatic test_done_drain();
    logic [17:0] exp_e [4];
    exp_e[0] = 18'h10001; exp_e[1] = 18'h10002; exp_e[2] = 18'h10003; exp_e[3] = 18'h300FF;
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) step(1, 1, 16'(i), 0);
    step(1, 3, 16'h00FF, 0);
    step(1, 1, 16'h0099, 0);
    n_checks++; if (o_Done !== 1'b1 || o_Done_Value !== 16'h00FF)
      $display("FAIL done_value got %b/%h want 1/00ff", o_Done, o_Done_Value); else n_pass++;
    n_checks++; if (o_Pass_Count !== 16'd3 || o_Log_Level !== LW'(4))
      $display("FAIL done_ignore got %0d/%0d want 3/4", o_Pass_Count, o_Log_Level); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (o_Log_Entry !== exp_e[i] || o_Halt !== 1'b0)
        $display("FAIL done_drain%0d got %h/%b want %h/0", i, o_Log_Entry, o_Halt, exp_e[i]); else n_pass++;
      step(0, 0, 0, 1);
    end
    n_checks++; if (o_Log_Level !== '0 || o_Halt !== 1'b0)
      $display("FAIL done_lvl0 got %0d/%b want 0/0", o_Log_Level, o_Halt); else n_pass++;
    step(0, 0, 0, 1);
    n_checks++; if (o_Halt !== 1'b1) $display("FAIL done_halt got %b want 1", o_Halt); else n_pass++;
  endtask

  task automatic test_gating();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 16'(i + 1), 0);
    n_checks++; if (o_Pass_Count !== 16'd0 || o_Log_Level !== '0)
      $display("FAIL gating got %0d/%0d want 0/0", o_Pass_Count, o_Log_Level); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] c;
    step(0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      c = 2'($urandom_range(0, 3));
      if (c == 2'd3 && $urandom_range(0, 15) != 0) c = 2'd1;
      if (m_halt || $urandom_range(0, 199) == 0)
        step(0, 0, 0, 0, 1);
      else
        step($urandom_range(0, 3) != 0, c, 16'($urandom), $urandom_range(0, 1) == 1);
      n_checks++; if (o_Log_Level !== LW'(q.size()) || o_Log_Valid !== (q.size() > 0))
        $display("FAIL rand_level got %0d/%b want %0d", o_Log_Level, o_Log_Valid, q.size()); else n_pass++;
      if (q.size() > 0) begin
        n_checks++; if (o_Log_Entry !== q[0]) $display("FAIL rand_entry got %h want %h", o_Log_Entry, q[0]); else n_pass++;
      end
      n_checks++; if (o_Pass_Count !== 16'(m_pass) || o_Fail_Count !== 16'(m_fail))
        $display("FAIL rand_counts got %0d/%0d want %0d/%0d", o_Pass_Count, o_Fail_Count, m_pass, m_fail); else n_pass++;
      n_checks++; if (o_First_Fail_Valid !== m_ff_vld || (m_ff_vld && o_First_Fail_Value !== m_ff_val))
        $display("FAIL rand_first_fail got %b/%h want %b/%h", o_First_Fail_Valid, o_First_Fail_Value, m_ff_vld, m_ff_val); else n_pass++;
      n_checks++; if (o_Done !== m_done || o_Done_Value !== m_done_val)
        $display("FAIL rand_done got %b/%h want %b/%h", o_Done, o_Done_Value, m_done, m_done_val); else n_pass++;
      n_checks++; if (o_Log_Overflow !== m_ovf || o_Halt !== m_halt)
        $display("FAIL rand_ovf_halt got %b/%b want %b/%b", o_Log_Overflow, o_Halt, m_ovf, m_halt); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 65537; i++) step(1, 1, 16'(i), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_checks++; if (o_Pass_Count !== 16'hFFFF) $display("FAIL sat_pass got %h want ffff", o_Pass_Count); else n_pass++;
    n_checks++; if (o_Log_Level !== '0) $display("FAIL sat_empty got %0d want 0", o_Log_Level); else n_pass++;
    step(1, 3, 16'h00AA, 1);
    n_checks++; if (o_Done !== 1'b1 || o_Log_Level !== LW'(1) || o_Halt !== 1'b0)
      $display("FAIL sat_done_n1 got %b/%0d/%b want 1/1/0", o_Done, o_Log_Level, o_Halt); else n_pass++;
    step(0, 0, 0, 1);
    n_checks++; if (o_Log_Level !== '0 || o_Halt !== 1'b0)
      $display("FAIL sat_done_n2 got %0d/%b want 0/0", o_Log_Level, o_Halt); else n_pass++;
    step(0, 0, 0, 1);
    n_checks++; if (o_Halt !== 1'b1) $display("FAIL sat_done_n3 got %b want 1", o_Halt); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if ({o_Log_Valid, o_Log_Level, o_Log_Overflow, o_Pass_Count, o_Fail_Count, o_First_Fail_Valid,
                     o_First_Fail_Value, o_Done, o_Done_Value, o_Halt, o_Log_Entry} !== '0)
      $display("FAIL halt_reset got pass=%h done=%b halt=%b lvl=%0d want all 0", o_Pass_Count, o_Done, o_Halt, o_Log_Level); else n_pass++;
    step(1, 1, 16'h0042, 0);
    n_checks++; if (o_Pass_Count !== 16'd1 || o_Log_Entry !== 18'h10042)
      $display("FAIL halt_reset_run got %0d/%h want 1/10042", o_Pass_Count, o_Log_Entry); else n_pass++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_first_fail();
    test_overflow();
    test_done_drain();
    test_gating();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
